// File: rtl/fml_bram_slave_if.sv
// FML port bundle: one burst request channel with
// byte-enabled 16-bit data in both directions.
interface fml_bram_slave_if #(
  parameter int fml_depth = 25
);
  logic [fml_depth-1:0] fml_adr;
  logic                 fml_stb;
  logic                 fml_we;
  logic                 fml_ack;
  logic [1:0]           fml_sel;
  logic [15:0]          fml_di;
  logic [15:0]          fml_do;

  modport master (
    output fml_adr, fml_stb, fml_we,
    output fml_sel, fml_di,
    input  fml_ack, fml_do
  );

  modport slave (
    input  fml_adr, fml_stb, fml_we,
    input  fml_sel, fml_di,
    output fml_ack, fml_do
  );
endinterface

// File: rtl/fml_bram_slave.sv
// FML responder on block RAM: 4-beat line bursts,
// programmable ack latency, byte-lane writes.
module fml_bram_slave #(
  parameter int fml_depth = 25,
  parameter int adr_width = 12,
  parameter int ack_wait  = 0
) (
  input logic             sys_clk,
  input logic             sys_rst_n,
  fml_bram_slave_if.slave fml
);
  localparam int words = 1 << adr_width;
  localparam logic [3:0] wait_load =
    (ack_wait > 0) ? 4'(ack_wait - 1) : 4'd0;

  typedef enum logic [2:0] {
    IDLE, WAIT, ACK, WBURST, RBURST
  } state_t;

  state_t state, state_nxt;
  logic [3:0] cnt, cnt_nxt;
  logic [1:0] beat, beat_nxt;
  logic [adr_width-3:0] line;
  logic we;
  logic wr_en, rd_en;
  logic [adr_width-1:0] idx;

  logic [7:0] mem_hi [words];
  logic [7:0] mem_lo [words];

  logic [fml_depth-1:0] unused_adr;
  assign unused_adr = fml.fml_adr;

  assign idx = {line, beat};

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    beat_nxt  = beat;
    wr_en     = 1'b0;
    rd_en     = 1'b0;
    unique case (state)
      IDLE: begin
        if (fml.fml_stb) begin
          if (ack_wait > 0) begin
            state_nxt = WAIT;
            cnt_nxt   = wait_load;
          end else begin
            state_nxt = ACK;
            beat_nxt  = 2'd0;
          end
        end
      end
      WAIT: begin
        if (cnt == 4'd0) begin
          state_nxt = ACK;
          beat_nxt  = 2'd0;
        end else begin
          cnt_nxt = cnt - 4'd1;
        end
      end
      ACK, WBURST, RBURST: begin
        wr_en    = we;
        rd_en    = !we;
        beat_nxt = beat + 2'd1;
        if (state == ACK)
          state_nxt = we ? WBURST : RBURST;
        else if (beat == 2'd3)
          state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state <= IDLE;
      cnt   <= 4'd0;
      beat  <= 2'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      beat  <= beat_nxt;
    end
  end

  // Request is captured only when IDLE accepts it
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      line <= '0;
      we   <= 1'b0;
    end else if (state == IDLE && fml.fml_stb) begin
      line <= fml.fml_adr[adr_width:3];
      we   <= fml.fml_we;
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      fml.fml_ack <= 1'b0;
      fml.fml_do  <= 16'h0000;
    end else begin
      fml.fml_ack <= (state_nxt == ACK);
      if (rd_en)
        fml.fml_do <= {mem_hi[idx], mem_lo[idx]};
    end
  end

  always_ff @(posedge sys_clk) begin
    if (wr_en) begin
      if (fml.fml_sel[1])
        mem_hi[idx] <= fml.fml_di[15:8];
      if (fml.fml_sel[0])
        mem_lo[idx] <= fml.fml_di[7:0];
    end
  end
endmodule

// File: tb/tb_fml_bram_slave.sv
// Bench for fml_bram_slave: directed bursts on two
// instances (ack_wait 0 and 3), scoreboard monitor.
module tb_fml_bram_slave;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int cyc = 0;
  int checks = 0;
  int errors = 0;
  int last_ack = 0;

  logic [24:0] adr [2];
  logic        stb [2];
  logic        we  [2];
  logic [1:0]  sel [2];
  logic [15:0] di  [2];

  fml_bram_slave_if b0 ();
  fml_bram_slave_if b1 ();

  assign b0.fml_adr = adr[0];
  assign b0.fml_stb = stb[0];
  assign b0.fml_we  = we[0];
  assign b0.fml_sel = sel[0];
  assign b0.fml_di  = di[0];
  assign b1.fml_adr = adr[1];
  assign b1.fml_stb = stb[1];
  assign b1.fml_we  = we[1];
  assign b1.fml_sel = sel[1];
  assign b1.fml_di  = di[1];

  wire [1:0] ackv = {b1.fml_ack, b0.fml_ack};
  logic [15:0] dov [2];
  assign dov[0] = b0.fml_do;
  assign dov[1] = b1.fml_do;

  fml_bram_slave #(
    .fml_depth(25), .adr_width(12), .ack_wait(0)
  ) u0 (
    .sys_clk(clk), .sys_rst_n(rst_n), .fml(b0.slave)
  );

  fml_bram_slave #(
    .fml_depth(25), .adr_width(12), .ack_wait(3)
  ) u1 (
    .sys_clk(clk), .sys_rst_n(rst_n), .fml(b1.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int inst;
    int cyc;
    bit we;
    logic [3:0][15:0] d;
  } ack_e;

  typedef struct {
    int inst;
    int cyc;
    logic [15:0] v;
  } dat_e;

  ack_e aq [$];
  dat_e dq [$];
  ack_e me;
  dat_e de;
  logic [1:0] pack = 2'b00;

  task automatic chk(string name, logic [31:0] act,
                     logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h",
               name, act, exp);
    end
  endtask

  function automatic logic [3:0][15:0] beats(
    logic [15:0] a, logic [15:0] b,
    logic [15:0] c, logic [15:0] d);
    return {d, c, b, a};
  endfunction

  function automatic logic [3:0][1:0] sels(
    logic [1:0] a, logic [1:0] b,
    logic [1:0] c, logic [1:0] d);
    return {d, c, b, a};
  endfunction

  function automatic int wt(int k);
    return (k == 1) ? 3 : 0;
  endfunction

  // Monitor: pops expected acks, schedules read beats
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (ackv[k]) begin
        chk("ack_gap", {31'd0, pack[k]}, 0);
        if (aq.size() == 0) begin
          chk("ack_unexpected", 1, 0);
        end else begin
          me = aq.pop_front();
          chk("ack_inst", k, me.inst);
          chk("ack_cycle", cyc, me.cyc);
          if (!me.we)
            for (int i = 0; i < 4; i++)
              dq.push_back('{k, cyc + 1 + i, me.d[i]});
        end
      end
    end
    pack <= ackv;
    while (dq.size() > 0 && dq[0].cyc <= cyc) begin
      de = dq.pop_front();
      if (de.cyc == cyc)
        chk("rdata", {16'd0, dov[de.inst]}, {16'd0, de.v});
      else
        chk("rdata_missed", de.cyc, cyc);
    end
  end

  task automatic wait_ack(int k, output bit ok);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!ackv[k] && n < 40);
    ok = ackv[k];
    if (!ok) chk("ack_timeout", 0, 1);
    else last_ack = cyc;
  endtask

  task automatic req(int k, logic [24:0] a, bit w,
                     logic [3:0][15:0] d,
                     logic [3:0][1:0] s,
                     bit cont, bit keep);
    ack_e e;
    bit ok;
    adr[k] = a;
    we[k]  = w;
    di[k]  = d[0];
    sel[k] = s[0];
    stb[k] = 1'b1;
    e.inst = k;
    e.we   = w;
    e.d    = d;
    e.cyc  = cont ? last_ack + 5 + wt(k) : cyc + 1 + wt(k);
    aq.push_back(e);
    wait_ack(k, ok);
    if (!ok) begin
      stb[k] = 1'b0;
      return;
    end
    for (int i = 1; i < 4; i++) begin
      @(posedge clk); #1;
      di[k]  = d[i];
      sel[k] = s[i];
      if (!keep) stb[k] = 1'b0;
    end
    @(posedge clk); #1;
  endtask

  logic [3:0][1:0] full;
  ack_e ie;
  bit iok;

  initial begin
    full = sels(2'b11, 2'b11, 2'b11, 2'b11);
    for (int k = 0; k < 2; k++) begin
      adr[k] = '0;
      stb[k] = 1'b0;
      we[k]  = 1'b0;
      sel[k] = 2'b00;
      di[k]  = 16'h0;
    end
    repeat (3) @(posedge clk);
    #1;
    chk("reset_ack0", {31'd0, ackv[0]}, 0);
    chk("reset_ack3", {31'd0, ackv[1]}, 0);
    chk("reset_do0", {16'd0, dov[0]}, 0);
    chk("reset_do3", {16'd0, dov[1]}, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    req(0, 25'h10, 1, beats(16'h1111, 16'h2222,
        16'h3333, 16'h4444), full, 0, 0);
    req(0, 25'h10, 0, beats(16'h1111, 16'h2222,
        16'h3333, 16'h4444), full, 0, 0);

    req(0, 25'h10, 1, beats(16'hAAAA, 16'hBBBB,
        16'hCCCC, 16'hDDDD),
        sels(2'b10, 2'b01, 2'b00, 2'b11), 0, 0);
    req(0, 25'h10, 0, beats(16'hAA11, 16'h22BB,
        16'h3333, 16'hDDDD), full, 0, 0);

    req(1, 25'h10, 1, beats(16'h0101, 16'h0202,
        16'h0303, 16'h0404), full, 0, 0);
    req(1, 25'h16, 0, beats(16'h0101, 16'h0202,
        16'h0303, 16'h0404), full, 0, 0);
    req(1, 25'h10, 0, beats(16'h0101, 16'h0202,
        16'h0303, 16'h0404), full, 0, 1);
    req(1, 25'h10, 0, beats(16'h0101, 16'h0202,
        16'h0303, 16'h0404), full, 1, 0);

    req(0, 25'h2010, 1, beats(16'h7001, 16'h7002,
        16'h7003, 16'h7004), full, 0, 0);
    req(0, 25'h10, 0, beats(16'h7001, 16'h7002,
        16'h7003, 16'h7004), full, 0, 0);

    req(0, 25'h18, 1, beats(16'h8001, 16'h8002,
        16'h8003, 16'h8004), full, 0, 0);
    req(0, 25'h10, 0, beats(16'h7001, 16'h7002,
        16'h7003, 16'h7004), full, 0, 1);
    req(0, 25'h18, 0, beats(16'h8001, 16'h8002,
        16'h8003, 16'h8004), full, 1, 0);

    req(0, 25'h20, 1, beats(16'h9001, 16'h9002,
        16'h9003, 16'h9004), full, 0, 1);
    req(0, 25'h20, 0, beats(16'h9001, 16'h9002,
        16'h9003, 16'h9004), full, 1, 0);

    req(0, 25'h40, 1, beats(16'h5551, 16'h5552,
        16'h5553, 16'h5554), full, 0, 0);
    req(0, 25'h40, 0, beats(16'h5551, 16'h5552,
        16'h5553, 16'h5554), full, 0, 0);

    // Write aborted by reset right after beat 1 lands
    adr[0] = 25'h40;
    we[0]  = 1'b1;
    di[0]  = 16'h6661;
    sel[0] = 2'b11;
    stb[0] = 1'b1;
    ie.inst = 0;
    ie.we   = 1'b1;
    ie.d    = '0;
    ie.cyc  = cyc + 1;
    aq.push_back(ie);
    wait_ack(0, iok);
    @(posedge clk); #1;
    di[0]  = 16'h6662;
    stb[0] = 1'b0;
    @(posedge clk); #1;
    di[0]  = 16'h6663;
    rst_n  = 1'b0;
    #1;
    chk("rst_ack", {31'd0, ackv[0]}, 0);
    chk("rst_do", {16'd0, dov[0]}, 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    req(0, 25'h40, 0, beats(16'h6661, 16'h6662,
        16'h5553, 16'h5554), full, 0, 0);

    repeat (10) @(posedge clk);
    #1;
    chk("ackq_empty", aq.size(), 0);
    chk("dataq_empty", dq.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end
endmodule
